spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_master.sv | 89 ++++++++
 tb/tb_spi_master.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// spi_master_if: host command and SPI pin bundle for spi_master.
interface spi_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    modport master (
        input  cmd_valid, cmd_type, cmd_data, miso,
        output cmd_ready, ss_n, mosi, rd_data, rd_valid, busy
    );
    modport slave (
        output cmd_valid, cmd_type, cmd_data, miso,
        input  cmd_ready, ss_n, mosi, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: sends a 10-bit {type, payload} SPI frame; read-data frames
// then wait TURNAROUND cycles and shift in one byte from miso.
module spi_master #(
    parameter int TURNAROUND = 2,
    parameter int END_HOLD   = 1
) (
    input logic           clk,
    input logic           rst_n,
    spi_master_if.master  bus_io
);
    typedef enum logic [2:0] {IDLE, CHK, SHIFT, WAIT, READ, HOLD, GAP} state_t;
    state_t     state_q;
    logic [3:0] cnt_q;
    logic [9:0] frame_q;
    logic [6:0] sh_q;
    logic       ss_n_q, mosi_q, rd_valid_q;
    logic [7:0] rd_data_q;
    assign bus_io.cmd_ready = state_q == IDLE;
    assign bus_io.busy      = state_q != IDLE;
    assign bus_io.ss_n      = ss_n_q;
    assign bus_io.mosi      = mosi_q;
    assign bus_io.rd_data   = rd_data_q;
    assign bus_io.rd_valid  = rd_valid_q;
    // Outputs are loaded one edge ahead, so each branch sets the values of the next state.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            sh_q       <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus_io.cmd_valid) begin
                    frame_q <= {bus_io.cmd_type, bus_io.cmd_data};
                    ss_n_q  <= 1'b0;
                    mosi_q  <= bus_io.cmd_type[1];
                    state_q <= CHK;
                end
                CHK: begin
                    mosi_q  <= frame_q[9];
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: if (cnt_q == 4'd9) begin
                    cnt_q  <= '0;
                    mosi_q <= 1'b0;
                    if (frame_q[9:8] == 2'b11) state_q <= WAIT;
                    else if (END_HOLD == 0) begin
                        ss_n_q  <= 1'b1;
                        state_q <= GAP;
                    end else state_q <= HOLD;
                end else begin
                    cnt_q  <= cnt_q + 4'd1;
                    mosi_q <= frame_q[4'd8 - cnt_q];
                end
                WAIT: if (cnt_q == 4'(TURNAROUND - 1)) begin
                    cnt_q   <= '0;
                    state_q <= READ;
                end else cnt_q <= cnt_q + 4'd1;
                READ: begin
                    sh_q <= {sh_q[5:0], bus_io.miso};
                    if (cnt_q == 4'd7) begin
                        cnt_q      <= '0;
                        rd_data_q  <= {sh_q, bus_io.miso};
                        rd_valid_q <= 1'b1;
                        ss_n_q     <= 1'b1;
                        state_q    <= GAP;
                    end else cnt_q <= cnt_q + 4'd1;
                end
                HOLD: if (cnt_q == 4'(END_HOLD - 1)) begin
                    cnt_q   <= '0;
                    ss_n_q  <= 1'b1;
                    state_q <= GAP;
                end else cnt_q <= cnt_q + 4'd1;
                GAP: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench with a SPI RAM slave model; the driver queues
// expected frames and read bytes, the monitor pops and compares them.
module tb_spi_master;
    localparam int TA = 2;
    localparam int EH = 1;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    spi_master_if bus ();
    spi_master #(.TURNAROUND(TA), .END_HOLD(EH)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    typedef struct { logic [9:0] f; int len; } exp_t;
    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    int checks = 0, errors = 0, cyc = 0, acc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    // Monitor: frame bits, frame length, idle mosi and read bytes.
    int c = 0;
    logic act_f = 1'b0, prev_ss = 1'b1, tail_bad = 1'b0;
    logic [10:0] sh = '0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            act_f   = 1'b0;
            prev_ss = 1'b1;
        end else begin
            if (!bus.ss_n) begin
                if (prev_ss) begin
                    c = 0; sh = '0; tail_bad = 1'b0; act_f = 1'b1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                        act_f = 1'b0;
                    end else cur = exp_q.pop_front();
                end
                if (c <= 10) sh = {sh[9:0], bus.mosi};
                else if (bus.mosi) tail_bad = 1'b1;
                c++;
            end else if (act_f) begin
                act_f = 1'b0;
                chk("frame_bits", sh, {cur.f[9], cur.f});
                chk("frame_len", c, cur.len);
                chk("tail_mosi", tail_bad, 0);
            end
            prev_ss = bus.ss_n;
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
                else chk("rd_data", bus.rd_data, rd_q.pop_front());
            end
        end
    end

    // SPI slave with a 256-byte RAM.
    logic [7:0] mem [256];
    logic [7:0] wa = '0, ra = '0, rb = '0;
    logic [9:0] sf = '0;
    int sc = 0;
    logic rdg = 1'b0;
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(negedge clk) begin
        if (!rst_n || bus.ss_n) begin
            sc = 0; rdg = 1'b0; bus.miso = 1'b0;
        end else begin
            if (sc >= 1 && sc <= 10) sf = {sf[8:0], bus.mosi};
            if (sc == 10)
                case (sf[9:8])
                    2'b00: wa = sf[7:0];
                    2'b01: mem[wa] = sf[7:0];
                    2'b10: ra = sf[7:0];
                    default: begin rb = mem[ra]; rdg = 1'b1; end
                endcase
            bus.miso = (rdg && sc >= 11 + TA && sc <= 18 + TA) ? rb[7 - (sc - 11 - TA)] : 1'b0;
            sc++;
        end
    end

    task automatic send(input logic [1:0] t, input logic [7:0] d, input bit keep,
                        input bit rd, input logic [7:0] rv);
        int n = 0;
        exp_q.push_back('{f: {t, d}, len: (t == 2'b11) ? 19 + TA : 11 + EH});
        if (rd) rd_q.push_back(rv);
        do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 100);
        if (!bus.cmd_ready) chk("accept_timeout", 0, 1);
        bus.cmd_valid = 1'b1; bus.cmd_type = t; bus.cmd_data = d;
        @(posedge clk); #1;
        acc = cyc;
        bus.cmd_data = ~d;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_sig(input int sel, output int at);
        int n = 0;
        logic s;
        do begin
            @(negedge clk); n++;
            s = (sel == 0) ? bus.ss_n : (sel == 1) ? bus.cmd_ready : bus.rd_valid;
        end while (!s && n < 60);
        if (!s) chk("wait_timeout", sel, 99);
        at = cyc;
    endtask

    int at, a1, a2, g;
    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_type = '0; bus.cmd_data = '0;
        rst_n = 1'b1; #1 rst_n = 1'b0; #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ss_n", bus.ss_n, 1);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(2'b00, 8'hA5, 0, 0, 0);
        wait_sig(0, at); chk("wa_ss_high_lat", at - acc, 12);
        wait_sig(1, at); chk("wa_ready_lat", at - acc, 13);
        send(2'b00, 8'h10, 0, 0, 0);
        send(2'b01, 8'h77, 0, 0, 0);
        send(2'b10, 8'h10, 0, 0, 0);
        send(2'b11, 8'h00, 0, 1, 8'h77);
        send(2'b00, 8'h05, 0, 0, 0);
        send(2'b01, 8'h3C, 0, 0, 0);
        send(2'b10, 8'h05, 0, 0, 0);
        send(2'b11, 8'hFF, 0, 1, 8'h3C);
        wait_sig(2, at); chk("rd_valid_lat", at - acc, 19 + TA);
        chk("rd_gap_ss_n", bus.ss_n, 1);
        @(negedge clk);
        chk("rd_valid_one_cycle", bus.rd_valid, 0);
        send(2'b00, 8'h99, 0, 0, 0);
        wait_sig(1, at); chk("rd_data_hold", bus.rd_data, 8'h3C);
        send(2'b01, 8'h11, 1, 0, 0); a1 = acc;
        send(2'b01, 8'h22, 1, 0, 0); a2 = acc;
        send(2'b01, 8'h33, 0, 0, 0);
        chk("b2b_period_1", a2 - a1, 13 + EH);
        chk("b2b_period_2", acc - a2, 13 + EH);
        send(2'b00, 8'h5A, 0, 0, 0);
        wait_sig(0, g);
        chk("gap_not_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'b10; bus.cmd_data = 8'h42;
        send(2'b10, 8'h42, 0, 0, 0);
        chk("gap_accept_cyc", acc - g, 2);
        wait_sig(1, at);
        send(2'b11, 8'h00, 0, 0, 0);
        repeat (16) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ss_n", bus.ss_n, 1);
        chk("abort_rd_valid", bus.rd_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rd_data", bus.rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(2'b00, 8'hC3, 0, 0, 0);
        wait_sig(1, at); chk("post_rst_ready_lat", at - acc, 13);
        repeat (5) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
